// File: rtl/apb_cmd_master.sv
// APB3 requester: converts a valid/ready command stream into single APB transfers
// and returns each completion (or wait-state timeout) as a valid/ready response.
module apb_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             run;

  // Reset release is retimed through one flop so no command is taken on the
  // first edge after reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  // Transfer sequencer; every output is a flop updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready && run) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A ready on the final allowed cycle still completes normally.
          if (pready) begin
            rsp_rdata   <= (pwrite || pslverr) ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            wait_cnt    <= wait_cnt + 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            wait_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a behavioural OR-accumulator APB slave
// and a response scoreboard.
module tb_apb_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t        sb[$];
  int          checks;
  int          failures;
  logic [7:0]  cur_addr;

  // Slave model state and knobs
  logic [31:0] s_data;
  logic [31:0] s_result;
  logic        s_done;
  int          acc_cnt;
  int          slv_waits;
  bit          slv_hang;
  logic        addr_ok;

  apb_cmd_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave response: garbage on prdata unless a legal read, so the requester's
  // masking of write/error data is observable.
  always_comb begin
    addr_ok = ((paddr == 8'h00) || (paddr == 8'h04) || (paddr == 8'h08)) &&
              !(pwrite && (paddr == 8'h08));
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'hA5A5A5A5;
    if (psel && penable) begin
      pready  = !slv_hang && (acc_cnt >= slv_waits);
      pslverr = pready && !addr_ok;
      if (!pwrite && addr_ok) begin
        case (paddr)
          8'h00:   prdata = s_data;
          8'h04:   prdata = {30'b0, s_done, 1'b0};
          default: prdata = s_result;
        endcase
      end
    end
  end

  // Slave registers: CONTROL bit0 ORs DATA into RESULT and sets the done flag.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= 0;
      s_data   <= '0;
      s_result <= '0;
      s_done   <= 1'b0;
    end else begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (psel && penable && pready && pwrite && !pslverr) begin
        if (paddr == 8'h00) s_data <= pwdata;
        if (paddr == 8'h04 && pwdata[0]) begin
          s_result <= s_result | s_data;
          s_done   <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic exp_to, input bit push);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cur_addr  = addr;
    if (push) sb.push_back({exp_rdata, exp_err, exp_to});
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    checkOutput("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collectResponse(input string tag, input int exp_psel, input int exp_pen,
                                 input int stall);
    int   psel_cnt;
    int   pen_cnt;
    bit   addr_moved;
    rsp_t exp;
    psel_cnt   = 0;
    pen_cnt    = 0;
    addr_moved = 0;
    exp        = '0;
    if (stall > 0) rsp_ready = 1'b0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      if (psel) psel_cnt++;
      if (penable) pen_cnt++;
      if (psel && paddr !== cur_addr) addr_moved = 1;
      @(negedge clk);
    end
    checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    checkOutput({tag, "_psel_cycles"}, psel_cnt, exp_psel);
    checkOutput({tag, "_penable_cycles"}, pen_cnt, exp_pen);
    checkOutput({tag, "_paddr_stable"}, {31'b0, addr_moved}, 32'd0);
    checkOutput({tag, "_sb_nonempty"}, {31'b0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    checkOutput({tag, "_rdata"}, rsp_rdata, exp.rdata);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp.err});
    checkOutput({tag, "_timeout"}, {31'b0, rsp_timeout}, {31'b0, exp.to});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_valid"}, {31'b0, rsp_valid}, 32'd1);
      checkOutput({tag, "_stall_rdata"}, rsp_rdata, exp.rdata);
      checkOutput({tag, "_stall_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
      checkOutput({tag, "_stall_psel"}, {31'b0, psel}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_rsp_done"}, {31'b0, rsp_valid}, 32'd0);
    checkOutput({tag, "_cmd_ready_back"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    bit seen_valid;
    checks    = 0;
    failures  = 0;
    slv_waits = 0;
    slv_hang  = 0;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h00;
    cmd_wdata = 32'h0;
    cur_addr  = 8'h00;

    // Reset with a command already pending
    repeat (3) @(negedge clk);
    checkOutput("rst_psel", {31'b0, psel}, 32'd0);
    checkOutput("rst_penable", {31'b0, penable}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("rst_paddr", {24'b0, paddr}, 32'd0);
    reset = 1'b0;
    sb.push_back({32'h0, 1'b0, 1'b0});
    @(negedge clk);
    checkOutput("rst_first_edge_idle", {31'b0, psel}, 32'd0);
    @(negedge clk);
    checkOutput("rst_second_edge_accept", {31'b0, psel}, 32'd1);
    cmd_valid = 1'b0;
    collectResponse("first", 2, 1, 0);

    // Accumulator flow
    $display("[TB] write/read sequence");
    applyStimulus(1'b1, 8'h00, 32'h0000000C, 32'h0, 1'b0, 1'b0, 1'b1);
    collectResponse("wr_data", 2, 1, 0);
    applyStimulus(1'b1, 8'h04, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b1);
    collectResponse("wr_ctrl", 2, 1, 0);
    applyStimulus(1'b0, 8'h08, 32'h0, 32'h0000000C, 1'b0, 1'b0, 1'b1);
    collectResponse("rd_result", 2, 1, 0);

    // Slave errors
    applyStimulus(1'b1, 8'h0C, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b1);
    collectResponse("err_badaddr", 2, 1, 0);
    applyStimulus(1'b1, 8'h08, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b1);
    collectResponse("err_ro", 2, 1, 0);

    // Wait states
    slv_waits = 3;
    applyStimulus(1'b0, 8'h04, 32'h0, 32'h00000002, 1'b0, 1'b0, 1'b1);
    collectResponse("wait3", 5, 4, 0);

    // Timeout, then ready on the last allowed cycle
    slv_hang = 1;
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    collectResponse("timeout", 17, 16, 0);
    slv_hang  = 0;
    slv_waits = 15;
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0000000C, 1'b0, 1'b0, 1'b1);
    collectResponse("ready_last", 17, 16, 0);

    // Response backpressure
    slv_waits = 0;
    applyStimulus(1'b0, 8'h08, 32'h0, 32'h0000000C, 1'b0, 1'b0, 1'b1);
    collectResponse("backpressure", 2, 1, 5);

    // Reset during ACCESS drops the transfer
    slv_hang = 1;
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    checkOutput("midop_in_access", {31'b0, penable}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midop_psel", {31'b0, psel}, 32'd0);
    checkOutput("midop_penable", {31'b0, penable}, 32'd0);
    checkOutput("midop_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || psel) seen_valid = 1;
    end
    checkOutput("midop_no_rsp", {31'b0, seen_valid}, 32'd0);
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
